// File: rtl/bus_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_xbar_pkg
// Description : Shared index-width helper and constants for the bus crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_xbar_pkg;

    localparam int c_MAX_DATA_WIDTH = 1024;

    // Read data returned to a host whose request hit no device region.
    localparam logic [c_MAX_DATA_WIDTH-1:0] c_UNMAPPED_RDATA = '0;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_xbar_prio_arb.sv
`default_nettype none
// ============================================================================
// Module      : bus_xbar_prio_arb
// Description : Lowest-index-wins priority encoder (one-hot, index, valid).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_xbar_prio_arb
    import bus_xbar_pkg::*;
#(
    parameter int N     = 1,
    parameter int IDX_W = sel_width(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scanning downwards lets the lowest set index overwrite higher ones.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
                o_valid     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_xbar.sv
`default_nettype none
// ============================================================================
// Module      : bus_xbar
// Description : Fixed-priority host/device crossbar, combinational request
//               path with one-cycle registered response steering.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_xbar
    import bus_xbar_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    host_req_i     [NrHosts],
    output logic                    host_gnt_o     [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
    input  logic                    host_we_i      [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
    output logic                    host_rvalid_o  [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
    output logic                    host_err_o     [NrHosts],

    output logic                    device_req_o   [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
    output logic                    device_we_o    [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
    input  logic                    device_rvalid_i[NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
    input  logic                    device_err_i   [NrDevices],

    input  logic [AddressWidth-1:0] cfg_device_addr_base[NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask[NrDevices]
);

    localparam int c_HOST_IDX_W = sel_width(NrHosts);
    localparam int c_DEV_IDX_W  = sel_width(NrDevices);

    logic [NrHosts-1:0]      w_host_req_vec;
    logic [NrHosts-1:0]      w_host_onehot;
    logic [c_HOST_IDX_W-1:0] w_host_idx;
    logic                    w_host_valid;

    logic [NrDevices-1:0]    w_dev_match;
    logic [NrDevices-1:0]    w_dev_onehot;
    logic [c_DEV_IDX_W-1:0]  w_dev_idx;
    logic                    w_dev_valid;

    logic [AddressWidth-1:0] w_addr;
    logic                    w_we;
    logic [DataWidth/8-1:0]  w_be;
    logic [DataWidth-1:0]    w_wdata;

    logic                    r_pending_q,   w_pending_d;
    logic                    r_unmapped_q,  w_unmapped_d;
    logic [c_HOST_IDX_W-1:0] r_resp_host_q, w_resp_host_d;
    logic [c_DEV_IDX_W-1:0]  r_resp_dev_q,  w_resp_dev_d;

    logic                    w_resp_live;
    logic                    w_sel_rvalid;
    logic                    w_sel_err;
    logic [DataWidth-1:0]    w_sel_rdata;

    // ------------------------------------------------------------------
    // Host arbitration
    // ------------------------------------------------------------------
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            w_host_req_vec[h] = host_req_i[h];
        end
    end

    bus_xbar_prio_arb #(
        .N     (NrHosts),
        .IDX_W (c_HOST_IDX_W)
    ) u_host_arb (
        .i_req    (w_host_req_vec),
        .o_onehot (w_host_onehot),
        .o_idx    (w_host_idx),
        .o_valid  (w_host_valid)
    );

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = w_host_onehot[h];
        end
    end

    // ------------------------------------------------------------------
    // Winning host broadcast and address decode
    // ------------------------------------------------------------------
    always_comb begin
        w_addr  = host_addr_i[w_host_idx];
        w_we    = host_we_i[w_host_idx];
        w_be    = host_be_i[w_host_idx];
        w_wdata = host_wdata_i[w_host_idx];
    end

    // Matches are qualified by a live request so an idle bus selects nothing.
    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            w_dev_match[d] = w_host_valid &&
                ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]);
        end
    end

    bus_xbar_prio_arb #(
        .N     (NrDevices),
        .IDX_W (c_DEV_IDX_W)
    ) u_dev_arb (
        .i_req    (w_dev_match),
        .o_onehot (w_dev_onehot),
        .o_idx    (w_dev_idx),
        .o_valid  (w_dev_valid)
    );

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = w_dev_onehot[d];
            device_addr_o[d]  = w_addr;
            device_we_o[d]    = w_we;
            device_be_o[d]    = w_be;
            device_wdata_o[d] = w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response steering registers
    // ------------------------------------------------------------------
    always_comb begin
        w_pending_d   = w_host_valid;
        w_unmapped_d  = w_host_valid & ~w_dev_valid;
        w_resp_host_d = r_resp_host_q;
        w_resp_dev_d  = r_resp_dev_q;
        if (w_host_valid) begin
            w_resp_host_d = w_host_idx;
            w_resp_dev_d  = w_dev_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending_q   <= 1'b0;
            r_unmapped_q  <= 1'b0;
            r_resp_host_q <= '0;
            r_resp_dev_q  <= '0;
        end else begin
            r_pending_q   <= w_pending_d;
            r_unmapped_q  <= w_unmapped_d;
            r_resp_host_q <= w_resp_host_d;
            r_resp_dev_q  <= w_resp_dev_d;
        end
    end

    // A reset landing while a response is due suppresses that response.
    always_comb begin
        w_resp_live  = r_pending_q & ~rst_i;
        w_sel_rvalid = r_unmapped_q ? 1'b1 : device_rvalid_i[r_resp_dev_q];
        w_sel_err    = r_unmapped_q ? 1'b1 : device_err_i[r_resp_dev_q];
        w_sel_rdata  = r_unmapped_q ? c_UNMAPPED_RDATA[DataWidth-1:0]
                                    : device_rdata_i[r_resp_dev_q];
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_err_o[h]    = 1'b0;
            host_rdata_o[h]  = '0;
            if (w_resp_live && (r_resp_host_q == c_HOST_IDX_W'(h))) begin
                host_rvalid_o[h] = w_sel_rvalid;
                host_err_o[h]    = w_sel_err;
                host_rdata_o[h]  = w_sel_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_xbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xbar
// Description : Directed self-checking bench for bus_xbar (2 hosts, 3 devices).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xbar;

    localparam int c_NH = 2;
    localparam int c_ND = 3;
    localparam int c_DW = 32;
    localparam int c_AW = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              host_req_i     [c_NH];
    logic              host_gnt_o     [c_NH];
    logic [c_AW-1:0]   host_addr_i    [c_NH];
    logic              host_we_i      [c_NH];
    logic [c_DW/8-1:0] host_be_i      [c_NH];
    logic [c_DW-1:0]   host_wdata_i   [c_NH];
    logic              host_rvalid_o  [c_NH];
    logic [c_DW-1:0]   host_rdata_o   [c_NH];
    logic              host_err_o     [c_NH];
    logic              device_req_o   [c_ND];
    logic [c_AW-1:0]   device_addr_o  [c_ND];
    logic              device_we_o    [c_ND];
    logic [c_DW/8-1:0] device_be_o    [c_ND];
    logic [c_DW-1:0]   device_wdata_o [c_ND];
    logic              device_rvalid_i[c_ND];
    logic [c_DW-1:0]   device_rdata_i [c_ND];
    logic              device_err_i   [c_ND];
    logic [c_AW-1:0]   cfg_base       [c_ND];
    logic [c_AW-1:0]   cfg_mask       [c_ND];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_xbar #(
        .NrDevices    (c_ND),
        .NrHosts      (c_NH),
        .DataWidth    (c_DW),
        .AddressWidth (c_AW)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .host_req_i           (host_req_i),
        .host_gnt_o           (host_gnt_o),
        .host_addr_i          (host_addr_i),
        .host_we_i            (host_we_i),
        .host_be_i            (host_be_i),
        .host_wdata_i         (host_wdata_i),
        .host_rvalid_o        (host_rvalid_o),
        .host_rdata_o         (host_rdata_o),
        .host_err_o           (host_err_o),
        .device_req_o         (device_req_o),
        .device_addr_o        (device_addr_o),
        .device_we_o          (device_we_o),
        .device_be_o          (device_be_o),
        .device_wdata_o       (device_wdata_o),
        .device_rvalid_i      (device_rvalid_i),
        .device_rdata_i       (device_rdata_i),
        .device_err_i         (device_err_i),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        for (int h = 0; h < c_NH; h++) begin
            host_req_i[h]   = 1'b0;
            host_addr_i[h]  = '0;
            host_we_i[h]    = 1'b0;
            host_be_i[h]    = '0;
            host_wdata_i[h] = '0;
        end
        for (int d = 0; d < c_ND; d++) begin
            device_rvalid_i[d] = 1'b0;
            device_rdata_i[d]  = '0;
            device_err_i[d]    = 1'b0;
        end
    endtask

    task automatic host_rd(input int h, input logic [31:0] addr);
        host_req_i[h]  = 1'b1;
        host_addr_i[h] = addr;
        host_we_i[h]   = 1'b0;
        host_be_i[h]   = 4'hF;
    endtask

    initial begin
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        chk("rst_rvalid0", 32'(host_rvalid_o[0]), 32'd0);
        chk("rst_err1",    32'(host_err_o[1]),    32'd0);
        rst_i = 1'b0;
        tick();
        chk("idle_rvalid0", 32'(host_rvalid_o[0]), 32'd0);
        chk("idle_rvalid1", 32'(host_rvalid_o[1]), 32'd0);

        // Host0 read from RAM
        host_rd(0, 32'h0010_0010);
        #1;
        chk("rd_gnt0",  32'(host_gnt_o[0]),   32'd1);
        chk("rd_gnt1",  32'(host_gnt_o[1]),   32'd0);
        chk("rd_dreq0", 32'(device_req_o[0]), 32'd1);
        chk("rd_dreq1", 32'(device_req_o[1]), 32'd0);
        chk("rd_dreq2", 32'(device_req_o[2]), 32'd0);
        tick();
        idle_inputs();
        device_rvalid_i[0] = 1'b1;
        device_rdata_i[0]  = 32'hDEAD_BEEF;
        #1;
        chk("rd_rvalid0", 32'(host_rvalid_o[0]), 32'd1);
        chk("rd_rdata0",  host_rdata_o[0],       32'hDEAD_BEEF);
        chk("rd_err0",    32'(host_err_o[0]),    32'd0);
        chk("rd_rvalid1", 32'(host_rvalid_o[1]), 32'd0);
        tick();
        idle_inputs();

        // Host0 write to SimCtrl
        host_req_i[0]   = 1'b1;
        host_addr_i[0]  = 32'h0002_0000;
        host_we_i[0]    = 1'b1;
        host_be_i[0]    = 4'h1;
        host_wdata_i[0] = 32'h41;
        #1;
        chk("wr_dreq1",  32'(device_req_o[1]),   32'd1);
        chk("wr_dreq0",  32'(device_req_o[0]),   32'd0);
        chk("wr_dreq2",  32'(device_req_o[2]),   32'd0);
        chk("wr_we1",    32'(device_we_o[1]),    32'd1);
        chk("wr_be1",    32'(device_be_o[1]),    32'h1);
        chk("wr_wdata1", device_wdata_o[1],      32'h41);
        tick();
        idle_inputs();
        device_rvalid_i[1] = 1'b1;
        tick();
        idle_inputs();

        // Simultaneous requests: host0 to Timer wins, host1 to RAM waits
        host_rd(0, 32'h0003_0004);
        host_rd(1, 32'h0010_0000);
        #1;
        chk("arb_gnt0",   32'(host_gnt_o[0]),   32'd1);
        chk("arb_gnt1",   32'(host_gnt_o[1]),   32'd0);
        chk("arb_dreq2",  32'(device_req_o[2]), 32'd1);
        chk("arb_dreq0",  32'(device_req_o[0]), 32'd0);
        chk("arb_daddr2", device_addr_o[2],     32'h0003_0004);
        tick();
        host_req_i[0]      = 1'b0;
        device_rvalid_i[2] = 1'b1;
        device_rdata_i[2]  = 32'h0000_1234;
        #1;
        chk("arb2_gnt1",    32'(host_gnt_o[1]),    32'd1);
        chk("arb2_dreq0",   32'(device_req_o[0]),  32'd1);
        chk("arb2_daddr0",  device_addr_o[0],      32'h0010_0000);
        chk("arb2_rvalid0", 32'(host_rvalid_o[0]), 32'd1);
        chk("arb2_rdata0",  host_rdata_o[0],       32'h0000_1234);
        chk("arb2_rvalid1", 32'(host_rvalid_o[1]), 32'd0);
        tick();
        idle_inputs();
        device_rvalid_i[0] = 1'b1;
        device_rdata_i[0]  = 32'h1234_5678;
        #1;
        chk("arb3_rvalid1", 32'(host_rvalid_o[1]), 32'd1);
        chk("arb3_rdata1",  host_rdata_o[1],       32'h1234_5678);
        chk("arb3_rvalid0", 32'(host_rvalid_o[0]), 32'd0);
        tick();
        idle_inputs();

        // Host1 unmapped access
        host_rd(1, 32'h0005_0000);
        #1;
        chk("um_gnt1",  32'(host_gnt_o[1]),   32'd1);
        chk("um_dreq0", 32'(device_req_o[0]), 32'd0);
        chk("um_dreq1", 32'(device_req_o[1]), 32'd0);
        chk("um_dreq2", 32'(device_req_o[2]), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("um_rvalid1", 32'(host_rvalid_o[1]), 32'd1);
        chk("um_err1",    32'(host_err_o[1]),    32'd1);
        chk("um_rdata1",  host_rdata_o[1],       32'd0);
        chk("um_rvalid0", 32'(host_rvalid_o[0]), 32'd0);
        tick();
        chk("um_idle_rvalid1", 32'(host_rvalid_o[1]), 32'd0);
        chk("um_idle_err1",    32'(host_err_o[1]),    32'd0);

        // Timer error response
        host_rd(0, 32'h0003_0008);
        tick();
        idle_inputs();
        device_rvalid_i[2] = 1'b1;
        device_err_i[2]    = 1'b1;
        #1;
        chk("terr_rvalid0", 32'(host_rvalid_o[0]), 32'd1);
        chk("terr_err0",    32'(host_err_o[0]),    32'd1);
        tick();
        idle_inputs();

        // Reset in the cycle after a grant drops the response
        host_rd(1, 32'h0003_0000);
        #1;
        chk("rr_gnt1", 32'(host_gnt_o[1]), 32'd1);
        tick();
        idle_inputs();
        rst_i              = 1'b1;
        device_rvalid_i[2] = 1'b1;
        #1;
        chk("rr_rvalid1_in_rst", 32'(host_rvalid_o[1]), 32'd0);
        tick();
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk("rr_rvalid1", 32'(host_rvalid_o[1]), 32'd0);
        chk("rr_err1",    32'(host_err_o[1]),    32'd0);
        chk("rr_resp_host", 32'(dut.r_resp_host_q), 32'd0);
        chk("rr_resp_dev",  32'(dut.r_resp_dev_q),  32'd0);
        chk("rr_unmapped",  32'(dut.r_unmapped_q),  32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
